// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined signed multiply-accumulate for the conv datapath.
// din0 is a signed A_W-bit operand; din1 is B_W bits, signed or unsigned as
// selected by B_SIGNED. Products pass through NUM_STAGE register stages,
// then get accumulated over a framed sequence. One sum is emitted per frame.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   ce         clock enable; low freezes every register
//   in_valid   beat present on din0/din1
//   in_first   beat opens a new sum (qualified by in_valid)
//   in_last    beat closes the current sum (qualified by in_valid)
//   din0       signed operand [A_W-1:0]
//   din1       operand [B_W-1:0], signedness per B_SIGNED
//   out_valid  dout holds a freshly completed sum (one enabled cycle)
//   dout       completed signed sum [ACC_W-1:0]
//   out_ovf    the sum in dout overflowed ACC_W at least once
//
// Build option: define CNN_MAC_SAT_EN to saturate the accumulator on
// overflow. Without it the accumulator wraps modulo 2^ACC_W. out_ovf is
// reported in both builds.
module cnn_mac_pipe #(
  parameter int A_W       = 14,
  parameter int B_W       = 7,
  parameter int B_SIGNED  = 0,
  parameter int NUM_STAGE = 2,
  parameter int ACC_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  output logic             out_valid,
  output logic [ACC_W-1:0] dout,
  output logic             out_ovf
);

  localparam int PW = A_W + B_W;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  logic [B_W:0]          b_ext;
  logic signed [A_W-1:0] a_q;
  logic [B_W:0]          b_q;
  logic [NUM_STAGE-1:0]  v_q, f_q, l_q;

  logic signed [PW-1:0]  a_x, b_x, prod, fin_p;
  logic                  fin_v, fin_f, fin_l;

  state_t                state;
  logic [ACC_W-1:0]      acc, acc_nx, p_ext, sum;
  logic                  ovf, ovf_nx, add_ovf, start, close;

  generate
    if (B_SIGNED != 0) begin : g_bsigned
      assign b_ext = {din1[B_W-1], din1};
    end else begin : g_bunsigned
      assign b_ext = {1'b0, din1};
    end
  endgenerate

  // Stage 1 holds the operands; control flags ride alongside every stage.
  // first/last are masked with valid here so later stages only see real beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      v_q <= '0;
      f_q <= '0;
      l_q <= '0;
    end else if (ce) begin
      a_q    <= din0;
      b_q    <= b_ext;
      v_q[0] <= in_valid;
      f_q[0] <= in_valid & in_first;
      l_q[0] <= in_valid & in_last;
      for (int unsigned i = 1; i < NUM_STAGE; i++) begin
        v_q[i] <= v_q[i-1];
        f_q[i] <= f_q[i-1];
        l_q[i] <= l_q[i-1];
      end
    end
  end

  // Both operands widened to PW bits; the PW-bit product is exact because
  // din1 carries at most B_W magnitude bits plus a sign.
  always_comb begin
    a_x  = {{B_W{a_q[A_W-1]}}, a_q};
    b_x  = {{(A_W-1){b_q[B_W]}}, b_q};
    prod = a_x * b_x;
  end

  generate
    if (NUM_STAGE == 1) begin : g_one_stage
      assign fin_p = prod;
    end else begin : g_multi_stage
      logic signed [PW-1:0] p_q [2:NUM_STAGE];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int unsigned i = 2; i <= NUM_STAGE; i++) begin
            p_q[i] <= '0;
          end
        end else if (ce) begin
          p_q[2] <= prod;
          for (int unsigned i = 3; i <= NUM_STAGE; i++) begin
            p_q[i] <= p_q[i-1];
          end
        end
      end

      assign fin_p = p_q[NUM_STAGE];
    end
  endgenerate

  assign fin_v = v_q[NUM_STAGE-1];
  assign fin_f = f_q[NUM_STAGE-1];
  assign fin_l = l_q[NUM_STAGE-1];

`ifdef CNN_MAC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  always_comb begin
    p_ext   = {{(ACC_W-PW){fin_p[PW-1]}}, fin_p};
    sum     = acc + p_ext;
    // Signed overflow: operands agree in sign but the result does not.
    add_ovf = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    start   = (state == S_IDLE) || fin_f;
    acc_nx  = acc;
    ovf_nx  = ovf;
    if (start) begin
      acc_nx = p_ext;
      ovf_nx = 1'b0;
    end else begin
      ovf_nx = ovf | add_ovf;
`ifdef CNN_MAC_SAT_EN
      // On overflow both operands share acc's sign, which picks the rail.
      if (add_ovf) begin
        acc_nx = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_nx = sum;
      end
`else
      acc_nx = sum;
`endif
    end
  end

  // Accumulator stage, followed by a separate output register so the
  // closing sum and the next frame's first term never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      acc       <= '0;
      ovf       <= 1'b0;
      close     <= 1'b0;
      out_valid <= 1'b0;
      dout      <= '0;
      out_ovf   <= 1'b0;
    end else if (ce) begin
      close     <= fin_v & fin_l;
      out_valid <= close;
      if (close) begin
        dout    <= acc;
        out_ovf <= ovf;
      end
      if (fin_v) begin
        acc   <= acc_nx;
        ovf   <= ovf_nx;
        state <= fin_l ? S_IDLE : S_RUN;
      end
    end
  end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Bench for cnn_mac_pipe: three instances with different widths, signedness
// and pipeline depths share one stimulus stream. A reference model folds each
// beat into an exact running sum and schedules the expected result at
// sample edge + NUM_STAGE + 1 in enabled-cycle time.
module tb_cnn_mac_pipe;

  localparam int NI = 3;
  localparam int NS  [NI] = '{2, 1, 4};
  localparam int AW  [NI] = '{32, 32, 22};
  localparam int BSG [NI] = '{0, 1, 0};
  localparam int DEPTH = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic        in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [13:0] din0 = '0;
  logic [6:0]  din1 = '0;

  logic        ov0, ov1, ov2;
  logic [31:0] d0, d1;
  logic [21:0] d2;
  logic        of0, of1, of2;

  cnn_mac_pipe #(.A_W(14), .B_W(7), .B_SIGNED(0), .NUM_STAGE(2), .ACC_W(32)) dut0 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov0), .dout(d0), .out_ovf(of0));

  cnn_mac_pipe #(.A_W(14), .B_W(7), .B_SIGNED(1), .NUM_STAGE(1), .ACC_W(32)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov1), .dout(d1), .out_ovf(of1));

  cnn_mac_pipe #(.A_W(14), .B_W(7), .B_SIGNED(0), .NUM_STAGE(4), .ACC_W(22)) dut2 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov2), .dout(d2), .out_ovf(of2));

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_errors = 0;
  int     ecount = 0;

  bit     open_s [NI];
  longint acc_m  [NI];
  bit     ovf_m  [NI];
  bit     exp_v  [NI][DEPTH];
  longint exp_d  [NI][DEPTH];
  bit     exp_o  [NI][DEPTH];
  longint held_d [NI];
  bit     held_o [NI];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit get_v(input int i);
    case (i)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic bit get_o(input int i);
    case (i)
      0:       return of0;
      1:       return of1;
      default: return of2;
    endcase
  endfunction

  function automatic longint get_d(input int i);
    longint r;
    case (i)
      0:       r = $signed(d0);
      1:       r = $signed(d1);
      default: r = $signed(d2);
    endcase
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      open_s[i] = 1'b0;
      acc_m[i]  = 0;
      ovf_m[i]  = 1'b0;
      held_d[i] = 0;
      held_o[i] = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        exp_v[i][k] = 1'b0;
        exp_d[i][k] = 0;
        exp_o[i][k] = 1'b0;
      end
    end
  endtask

  // Exact arithmetic, then wrap or clamp back into ACC_W signed range.
  task automatic model_beat(input bit f, input bit l, input int a, input int b);
    longint p, t, mx, mn, bv;
    int     idx;
    for (int i = 0; i < NI; i++) begin
      bv = (BSG[i] != 0 && b >= 64) ? longint'(b - 128) : longint'(b);
      p  = longint'(a) * bv;
      mx = (64'sd1 <<< (AW[i] - 1)) - 1;
      mn = -(64'sd1 <<< (AW[i] - 1));
      if (!open_s[i] || f) begin
        acc_m[i] = p;
        ovf_m[i] = 1'b0;
      end else begin
        t = acc_m[i] + p;
        if (t > mx || t < mn) begin
          ovf_m[i] = 1'b1;
`ifdef CNN_MAC_SAT_EN
          t = (t > mx) ? mx : mn;
`else
          if (t > mx) t = t - (64'sd1 <<< AW[i]);
          else        t = t + (64'sd1 <<< AW[i]);
`endif
        end
        acc_m[i] = t;
      end
      open_s[i] = !l;
      if (l) begin
        idx = ecount + NS[i] + 1;
        exp_v[i][idx] = 1'b1;
        exp_d[i][idx] = acc_m[i];
        exp_o[i][idx] = ovf_m[i];
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NI; i++) begin
      if (exp_v[i][ecount]) begin
        held_d[i] = exp_d[i][ecount];
        held_o[i] = exp_o[i][ecount];
      end
      check($sformatf("i%0d.out_valid", i), longint'(get_v(i)), longint'(exp_v[i][ecount]));
      check($sformatf("i%0d.dout", i), get_d(i), held_d[i]);
      check($sformatf("i%0d.out_ovf", i), longint'(get_o(i)), longint'(held_o[i]));
    end
  endtask

  task automatic tick(input bit v, input bit f, input bit l, input int a, input int b,
                      input bit c = 1'b1);
    logic [31:0] av, bv;
    av = a;
    bv = b;
    in_valid = v;
    in_first = f;
    in_last  = l;
    din0     = av[13:0];
    din1     = bv[6:0];
    ce       = c;
    @(posedge clk);
    if (c) begin
      ecount++;
      if (v) model_beat(f, l, a, b);
    end
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("i%0d.rst_valid", i), longint'(get_v(i)), 0);
      check($sformatf("i%0d.rst_dout", i), get_d(i), 0);
      check($sformatf("i%0d.rst_ovf", i), longint'(get_o(i)), 0);
    end
    model_clear();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("i%0d.init_valid", i), longint'(get_v(i)), 0);
      check($sformatf("i%0d.init_dout", i), get_d(i), 0);
    end
    reset = 1'b0;
    idle(2);

    // Single-term sum
    tick(1, 1, 1, -3, 100);
    idle(6);
    check("single_term", get_d(0), -300);

    // Operand extremes
    tick(1, 1, 1, 8191, 127);
    tick(1, 1, 1, -8192, 127);
    idle(6);
    check("extreme_neg_unsigned", get_d(0), -1040384);
    check("extreme_signed_b", get_d(1), 8192);

    // Four-beat sum, then an immediate single-term sum, then a discard
    tick(1, 1, 0, 10, 5);
    tick(1, 0, 0, -20, 3);
    tick(1, 0, 0, 7, 127);
    tick(1, 0, 1, 1, 1);
    tick(1, 1, 1, 2, 2);
    idle(6);
    check("back_to_back", get_d(0), 4);
    tick(1, 1, 0, 5, 5);
    tick(1, 1, 1, 1, 1);
    idle(6);
    check("first_discard", get_d(0), 1);

    // ce stall mid-sum (garbage on inputs while disabled), then a stall at the output
    tick(1, 1, 0, 10, 5);
    tick(1, 0, 0, -20, 3);
    tick(1, 1, 1, 99, 99, 1'b0);
    tick(1, 0, 1, 42, 42, 1'b0);
    tick(1, 0, 0, 7, 127);
    tick(1, 0, 1, 1, 1);
    idle(2);
    tick(0, 0, 0, 0, 0, 1'b0);
    tick(0, 0, 0, 0, 0, 1'b0);
    idle(5);
    check("ce_stall_sum", get_d(0), 880);

    // Overflow in the 22-bit instance, then a clean sum
    tick(1, 1, 0, -8192, 127);
    tick(1, 0, 0, -8192, 127);
    tick(1, 0, 1, -8192, 127);
    idle(7);
`ifdef CNN_MAC_SAT_EN
    check("ovf_sum_acc22", get_d(2), -2097152);
`else
    check("ovf_sum_acc22", get_d(2), 1073152);
`endif
    check("ovf_flag_acc22", longint'(of2), 1);
    tick(1, 1, 1, 2, 2);
    idle(7);
    check("ovf_clear_acc22", longint'(of2), 0);

    // Reset after two of four beats
    tick(1, 1, 0, 1, 2);
    tick(1, 0, 0, 3, 4);
    pulse_reset();
    tick(1, 1, 1, 2, 2);
    idle(7);
    check("post_reset_sum", get_d(0), 4);

    // Randomized traffic with occasional stalls and resets
    for (int n = 0; n < 3000; n++) begin
      bit v, f, l, c;
      int a, b;
      v = ($urandom % 4) != 0;
      f = ($urandom % 6) == 0;
      l = ($urandom % 4) == 0;
      c = ($urandom % 8) != 0;
      case ($urandom % 8)
        0:       a = -8192;
        1:       a = 8191;
        default: a = int'($urandom_range(0, 16383)) - 8192;
      endcase
      b = ($urandom % 5 == 0) ? 127 : int'($urandom_range(0, 127));
      tick(v, f, l, a, b, c);
      if (($urandom % 400) == 0) pulse_reset();
    end
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
